ir_poll_ctrl: RTL and testbench
===============================

# ir_poll_ctrl

Polling scheduler for the infrared bump/dip sensor on the UART link. Periodically transmits a query byte through the UART transmitter and waits for the one-byte reply from the UART receiver. Decodes the reply into the 2-bit bump/dip flag and retries on timeout or a malformed reply. Declares a sensor fault after repeated failures. Sits between the 9600-baud UART TX/RX pair and the application logic that consumes `flag_tu_ao`.

## Interface
- `POLL_CYCLES`, 5_000_000: clocks from entry to WAIT_POLL until the next query (100 ms at 50 MHz).
- `TIMEOUT_CYCLES`, 500_000: clocks allowed for a reply after TX completes (10 ms).
- `MAX_RETRY`, 3: consecutive failed transactions before `sensor_fault`; must be ≥1.
- `QUERY_BYTE`, 8'hA5: byte sent as the query.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-high.
- `en`  in  1  enables polling; sampled only in IDLE and WAIT_POLL.
- `tx_busy`  in  1  UART transmitter busy.
- `tx_done`  in  1  one-cycle pulse when the transmitter finishes a byte.
- `tx_start`  out  1  one-cycle request to the transmitter.
- `tx_data`  out  8  byte to transmit; constant `QUERY_BYTE`.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid on that cycle.
- `rx_data`  in  8  received byte.
- `flag_tu_ao`  out  2  last good reading: 00 flat, 01 bump (tu), 10 dip (ao).
- `flag_valid`  out  1  one-cycle pulse when `flag_tu_ao` is updated.
- `sensor_fault`  out  1  sticky until the next good reply.

## Operation
- FSM states: IDLE, WAIT_POLL, SEND, WAIT_TX, WAIT_RX.
- **IDLE**
  - If `en`=1, go to WAIT_POLL and clear the poll counter.
- **WAIT_POLL**
  - If `en`=0, go to IDLE.
  - Otherwise the poll counter increments each cycle. At count `POLL_CYCLES`-1, go to SEND.
- **SEND**
  - Wait while `tx_busy`=1.
  - On the first cycle with `tx_busy`=0, assert `tx_start` for that one cycle and go to WAIT_TX.
- **WAIT_TX**
  - On `tx_done`, go to WAIT_RX and clear the timeout counter.
  - No timeout in this state.
- **WAIT_RX**
  - The timeout counter increments each cycle.
  - `rx_valid` with `rx_data` 8'h00/8'h01/8'h02 is a good reply:
    - `flag_tu_ao` is set to 00/01/10 and `flag_valid` pulses.
    - `retry_cnt` and `sensor_fault` are cleared.
    - Go to WAIT_POLL with the poll counter cleared.
  - `rx_valid` with any other byte, or the timeout counter reaching `TIMEOUT_CYCLES`-1, is a failure. `retry_cnt` increments:
    - If the new `retry_cnt` < `MAX_RETRY`, go to SEND (immediate retry, no poll wait).
    - Otherwise set `sensor_fault`=1, clear `retry_cnt`, and go to WAIT_POLL.
- `rx_valid` outside WAIT_RX is ignored. Stray bytes do not change the flags.
- On failure, `flag_tu_ao` holds its last good value.
- `en` falling mid-transaction (SEND/WAIT_TX/WAIT_RX) does not abort. The transaction completes, then the FSM exits to IDLE from WAIT_POLL on the next cycle.
- Counter widths: `$clog2` of the respective parameter. `retry_cnt` width is `$clog2(MAX_RETRY+1)`.

## Timing
- Reset values:
  - state IDLE
  - `tx_start`=0
  - `tx_data`=`QUERY_BYTE`
  - `flag_tu_ao`=00
  - `flag_valid`=0
  - `sensor_fault`=0
  - all counters 0
- Reset mid-transaction returns to IDLE immediately. A pending reply is discarded.
- All outputs are registered.
- `tx_start` is high exactly one cycle per query, and never while `tx_busy`=1.
- Query spacing: the first `tx_start` occurs `POLL_CYCLES`+1 cycles after `en` is sampled high in IDLE, provided `tx_busy`=0.
- Good-reply latency: `flag_tu_ao` and `flag_valid` update on the clock edge after the `rx_valid` cycle.
- Timeout fires on the edge ending the `TIMEOUT_CYCLES`-th WAIT_RX cycle.
- If `rx_valid` arrives on the same cycle as the timeout count, the byte wins and the timeout is not counted.
- If `tx_done` and `rx_valid` are coincident in WAIT_TX, `rx_valid` is ignored.

## Test plan
Use `POLL_CYCLES`=20, `TIMEOUT_CYCLES`=50, `MAX_RETRY`=2 throughout.

- Normal poll: `en`=1, transmitter model returns `tx_done` 10 cycles after `tx_start`, reply 8'h01 5 cycles later.
  - Expect `tx_data`=8'hA5.
  - Expect `flag_tu_ao`=01 and a 1-cycle `flag_valid`.
  - Expect the next `tx_start` 21 cycles after the reply.
- Decode set: replies 8'h00, 8'h02, then 8'h01 on successive polls.
  - Expect `flag_tu_ao` sequence 00, 10, 01.
  - Expect `sensor_fault` to stay 0.
- Timeout/fault: no reply.
  - Expect a retry `tx_start` right after the first timeout.
  - After the second timeout, expect `sensor_fault`=1 and `flag_tu_ao` unchanged.
  - A later good 8'h02 reply must clear `sensor_fault` and give `flag_tu_ao`=10.
- Bad byte: reply 8'h7F, then 8'h00 on the retry.
  - Expect no `flag_valid` on 8'h7F.
  - Expect an immediate retry, then `flag_tu_ao`=00 with `sensor_fault`=0.
- Busy/stray/en:
  - Hold `tx_busy`=1 for 30 cycles at SEND: expect `tx_start` only after `tx_busy` drops.
  - Inject `rx_valid` 8'h01 during WAIT_POLL: expect it ignored.
  - Drop `en` during WAIT_RX: expect the reply still processed, then IDLE with no further `tx_start`.
- Reset: assert `rst` during WAIT_RX.
  - Expect all outputs at reset values immediately.
  - Expect a reply strobe delivered during reset to be ignored.

Source files
------------

// File: rtl/ir_poll_ctrl.sv
// Polling scheduler for the IR bump/dip sensor over a UART TX/RX pair.
// Sends a query byte, decodes the one-byte reply, retries and flags a sensor fault.
module ir_poll_ctrl #(
   parameter int          POLL_CYCLES    = 5_000_000,
   parameter int          TIMEOUT_CYCLES = 500_000,
   parameter int          MAX_RETRY      = 3,
   parameter logic [7:0]  QUERY_BYTE     = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       tx_busy,
   input  logic       tx_done,
   output logic       tx_start,
   output logic [7:0] tx_data,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic [1:0] flag_tu_ao,
   output logic       flag_valid,
   output logic       sensor_fault
);

   localparam int POLL_W  = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
   localparam int TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int RETRY_W = $clog2(MAX_RETRY + 1);

   localparam logic [POLL_W-1:0]  POLL_LAST = POLL_W'(POLL_CYCLES - 1);
   localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_POLL,
      SEND,
      WAIT_TX,
      WAIT_RX
   } state_t;

   state_t             state, state_nxt;
   logic [POLL_W-1:0]  poll_cnt, poll_nxt;
   logic [TO_W-1:0]    to_cnt, to_nxt;
   logic [RETRY_W-1:0] retry_cnt, retry_nxt, retry_inc;
   logic               start_nxt;
   logic [1:0]         flag_nxt;
   logic               fvalid_nxt;
   logic               fault_nxt;
   logic               good_reply;
   logic               fail;

   // Valid replies are exactly 8'h00, 8'h01 and 8'h02.
   assign good_reply = (rx_data[7:2] == 6'd0) && (rx_data[1:0] != 2'b11);
   assign retry_inc  = retry_cnt + RETRY_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      poll_nxt   = poll_cnt;
      to_nxt     = to_cnt;
      retry_nxt  = retry_cnt;
      start_nxt  = 1'b0;
      flag_nxt   = flag_tu_ao;
      fvalid_nxt = 1'b0;
      fault_nxt  = sensor_fault;
      fail       = 1'b0;

      case (state)
         IDLE: begin
            if (en) begin
               state_nxt = WAIT_POLL;
               poll_nxt  = '0;
            end
         end
         WAIT_POLL: begin
            if (!en) begin
               state_nxt = IDLE;
            end else if (poll_cnt == POLL_LAST) begin
               state_nxt = SEND;
               poll_nxt  = '0;
            end else begin
               poll_nxt = poll_cnt + POLL_W'(1);
            end
         end
         SEND: begin
            if (!tx_busy) begin
               start_nxt = 1'b1;
               state_nxt = WAIT_TX;
            end
         end
         WAIT_TX: begin
            if (tx_done) begin
               state_nxt = WAIT_RX;
               to_nxt    = '0;
            end
         end
         WAIT_RX: begin
            to_nxt = to_cnt + TO_W'(1);
            // A byte arriving on the timeout cycle takes priority over the timeout.
            if (rx_valid) begin
               if (good_reply) begin
                  flag_nxt   = rx_data[1:0];
                  fvalid_nxt = 1'b1;
                  retry_nxt  = '0;
                  fault_nxt  = 1'b0;
                  state_nxt  = WAIT_POLL;
                  poll_nxt   = '0;
               end else begin
                  fail = 1'b1;
               end
            end else if (to_cnt == TO_LAST) begin
               fail = 1'b1;
            end

            if (fail) begin
               if (retry_inc < RETRY_MAX) begin
                  retry_nxt = retry_inc;
                  state_nxt = SEND;
               end else begin
                  retry_nxt = '0;
                  fault_nxt = 1'b1;
                  state_nxt = WAIT_POLL;
                  poll_nxt  = '0;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         poll_cnt     <= '0;
         to_cnt       <= '0;
         retry_cnt    <= '0;
         tx_start     <= 1'b0;
         tx_data      <= QUERY_BYTE;
         flag_tu_ao   <= 2'b00;
         flag_valid   <= 1'b0;
         sensor_fault <= 1'b0;
      end else begin
         poll_cnt     <= poll_nxt;
         to_cnt       <= to_nxt;
         retry_cnt    <= retry_nxt;
         tx_start     <= start_nxt;
         tx_data      <= QUERY_BYTE;
         flag_tu_ao   <= flag_nxt;
         flag_valid   <= fvalid_nxt;
         sensor_fault <= fault_nxt;
      end
   end

endmodule

// File: tb/tb_ir_poll_ctrl.sv
// Directed bench for ir_poll_ctrl with short poll/timeout periods.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_ir_poll_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic [1:0] flag_tu_ao;
   logic       flag_valid;
   logic       sensor_fault;

   int checks = 0;
   int errors = 0;
   int gap;
   int seen;

   ir_poll_ctrl #(
      .POLL_CYCLES   (20),
      .TIMEOUT_CYCLES(50),
      .MAX_RETRY     (2),
      .QUERY_BYTE    (8'hA5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .flag_tu_ao  (flag_tu_ao),
      .flag_valid  (flag_valid),
      .sensor_fault(sensor_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Returns the number of falling edges until tx_start is seen, or -1.
   task automatic wait_start(input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         tick();
         if (tx_start === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   // Transmitter model: tx_done 10 cycles after the tx_start cycle.
   task automatic do_tx();
      chk("tx_data", 32'(tx_data), 32'h A5);
      tick();
      chk("tx_start_one_cycle", 32'(tx_start), 32'd0);
      repeat (8) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
   endtask

   // Reply strobe 5 cycles after tx_done; returns on the edge after it.
   task automatic reply(input logic [7:0] d);
      repeat (4) tick();
      rx_valid = 1'b1;
      rx_data  = d;
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   logic [7:0] dec_byte [3] = '{8'h00, 8'h02, 8'h01};
   logic [1:0] dec_flag [3] = '{2'b00, 2'b10, 2'b01};

   initial begin
      rst = 1'b1; en = 1'b0; tx_busy = 1'b0; tx_done = 1'b0;
      rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) tick();
      chk("rst_tx_start", 32'(tx_start), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'h A5);
      chk("rst_flag", 32'(flag_tu_ao), 32'd0);
      chk("rst_flag_valid", 32'(flag_valid), 32'd0);
      chk("rst_fault", 32'(sensor_fault), 32'd0);
      rst = 1'b0;
      tick();

      // normal poll
      en = 1'b1;
      wait_start(100, gap);
      chk("first_query_gap", 32'(gap), 32'd22);
      do_tx();
      reply(8'h01);
      chk("normal_flag", 32'(flag_tu_ao), 32'd1);
      chk("normal_valid", 32'(flag_valid), 32'd1);
      tick();
      chk("normal_valid_pulse", 32'(flag_valid), 32'd0);
      wait_start(100, gap);
      chk("reply_to_query_gap", 32'(gap), 32'd20);

      // decode set
      for (int k = 0; k < 3; k++) begin
         do_tx();
         reply(dec_byte[k]);
         chk("decode_flag", 32'(flag_tu_ao), 32'(dec_flag[k]));
         chk("decode_valid", 32'(flag_valid), 32'd1);
         chk("decode_fault", 32'(sensor_fault), 32'd0);
         wait_start(100, gap);
         chk("decode_gap", 32'(gap), 32'd21);
      end

      // timeout, retry, fault
      do_tx();
      wait_start(100, gap);
      chk("timeout_retry_gap", 32'(gap), 32'd51);
      do_tx();
      repeat (49) tick();
      chk("fault_before_timeout", 32'(sensor_fault), 32'd0);
      tick();
      chk("fault_after_timeout", 32'(sensor_fault), 32'd1);
      chk("fault_flag_hold", 32'(flag_tu_ao), 32'd1);
      wait_start(100, gap);
      chk("fault_next_poll_gap", 32'(gap), 32'd21);
      do_tx();
      reply(8'h02);
      chk("fault_clear", 32'(sensor_fault), 32'd0);
      chk("fault_clear_flag", 32'(flag_tu_ao), 32'd2);

      // bad byte then good retry
      wait_start(100, gap);
      chk("bad_poll_gap", 32'(gap), 32'd21);
      do_tx();
      reply(8'h7F);
      chk("bad_no_valid", 32'(flag_valid), 32'd0);
      chk("bad_flag_hold", 32'(flag_tu_ao), 32'd2);
      wait_start(100, gap);
      chk("bad_retry_gap", 32'(gap), 32'd1);
      do_tx();
      reply(8'h00);
      chk("bad_retry_flag", 32'(flag_tu_ao), 32'd0);
      chk("bad_retry_valid", 32'(flag_valid), 32'd1);
      chk("bad_retry_fault", 32'(sensor_fault), 32'd0);

      // transmitter busy holds off the query
      tx_busy = 1'b1;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (tx_start === 1'b1) seen++;
      end
      chk("busy_no_start", 32'(seen), 32'd0);
      tx_busy = 1'b0;
      wait_start(10, gap);
      chk("busy_release_gap", 32'(gap), 32'd1);
      do_tx();
      reply(8'h02);
      chk("busy_flag", 32'(flag_tu_ao), 32'd2);

      // stray byte during WAIT_POLL
      tick();
      tick();
      rx_valid = 1'b1;
      rx_data  = 8'h01;
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      chk("stray_no_valid", 32'(flag_valid), 32'd0);
      chk("stray_flag_hold", 32'(flag_tu_ao), 32'd2);
      wait_start(100, gap);
      chk("stray_poll_gap", 32'(gap), 32'd18);

      // en drops during WAIT_RX
      do_tx();
      en = 1'b0;
      reply(8'h01);
      chk("endrop_flag", 32'(flag_tu_ao), 32'd1);
      chk("endrop_valid", 32'(flag_valid), 32'd1);
      wait_start(60, gap);
      chk("endrop_no_start", 32'(gap), 32'hFFFF_FFFF);
      en = 1'b1;
      wait_start(100, gap);
      chk("endrop_idle_gap", 32'(gap), 32'd22);

      // reset during WAIT_RX with a reply strobe inside reset
      do_tx();
      repeat (2) tick();
      rst      = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h02;
      #1;
      chk("async_rst_flag", 32'(flag_tu_ao), 32'd0);
      chk("async_rst_valid", 32'(flag_valid), 32'd0);
      chk("async_rst_start", 32'(tx_start), 32'd0);
      chk("async_rst_fault", 32'(sensor_fault), 32'd0);
      chk("async_rst_txdata", 32'(tx_data), 32'h A5);
      tick();
      chk("rst_reply_ignored_flag", 32'(flag_tu_ao), 32'd0);
      chk("rst_reply_ignored_valid", 32'(flag_valid), 32'd0);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      rst      = 1'b0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (flag_valid === 1'b1) seen++;
      end
      chk("post_rst_no_valid", 32'(seen), 32'd0);
      chk("post_rst_flag", 32'(flag_tu_ao), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
